// File: rtl/pe_edge_feeder.sv
// Edge feeder for a bit-serial PE row: turns each accepted (ifm, wght) pair into an IWIDTH-cycle MAC slot.
// PE-facing outputs are registered (1 cycle after the decision); in_ready is high only in LOAD, stalls hold idx at 0.
module pe_edge_feeder #(
    parameter int IWIDTH = 8,
    parameter int IDEPTH = 3,
    parameter int KWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KWIDTH-1:0] cfg_k,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IWIDTH-1:0] in_ifm,
    input  logic [IWIDTH-1:0] in_wght,
    output logic [IDEPTH-1:0] idx,
    output logic              mac_done,
    output logic              en_i,
    output logic              en_w,
    output logic              clr_i,
    output logic              clr_w,
    output logic              clr_o,
    output logic              en_o,
    output logic [IWIDTH-1:0] ifm,
    output logic [IWIDTH-1:0] wght
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [KWIDTH-1:0]   k_rem_q, k_rem_d;
    logic [IDEPTH-1:0]   step_q, step_d;
    logic [IDEPTH-1:0]   idx_q, idx_d;
    logic                mac_done_q, mac_done_d;
    logic                en_iw_q, en_iw_d;
    logic                en_o_q, en_o_d;
    logic                clr_q, clr_d;
    logic [IWIDTH-1:0]   ifm_q, ifm_d;
    logic [IWIDTH-1:0]   wght_q, wght_d;

    localparam logic [IDEPTH-1:0] LAST_STEP = IDEPTH'(IWIDTH - 1);

    always_comb begin
        state_d    = state_q;
        k_rem_d    = k_rem_q;
        step_d     = step_q;
        idx_d      = '0;
        mac_done_d = 1'b0;
        en_iw_d    = 1'b0;
        en_o_d     = 1'b0;
        clr_d      = 1'b0;
        ifm_d      = ifm_q;
        wght_d     = wght_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_rem_d = cfg_k;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_d   = 1'b1;
                state_d = (k_rem_q != '0) ? S_LOAD : S_DONE;
            end
            S_LOAD: begin
                if (in_valid) begin
                    ifm_d   = in_ifm;
                    wght_d  = in_wght;
                    en_iw_d = 1'b1;
                    en_o_d  = 1'b1;
                    if (k_rem_q != '0) begin
                        k_rem_d = k_rem_q - KWIDTH'(1);
                    end
                    step_d  = IDEPTH'(1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                idx_d  = step_q;
                en_o_d = 1'b1;
                // Last step hands straight back to LOAD so consecutive slots have no bubble.
                if (step_q == LAST_STEP) begin
                    mac_done_d = 1'b1;
                    state_d    = (k_rem_q != '0) ? S_LOAD : S_DONE;
                end else begin
                    step_d = step_q + IDEPTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_rem_q    <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            mac_done_q <= 1'b0;
            en_iw_q    <= 1'b0;
            en_o_q     <= 1'b0;
            clr_q      <= 1'b0;
            ifm_q      <= '0;
            wght_q     <= '0;
        end else begin
            state_q    <= state_d;
            k_rem_q    <= k_rem_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            mac_done_q <= mac_done_d;
            en_iw_q    <= en_iw_d;
            en_o_q     <= en_o_d;
            clr_q      <= clr_d;
            ifm_q      <= ifm_d;
            wght_q     <= wght_d;
        end
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign idx      = idx_q;
    assign mac_done = mac_done_q;
    assign en_i     = en_iw_q;
    assign en_w     = en_iw_q;
    assign en_o     = en_o_q;
    assign clr_i    = clr_q;
    assign clr_w    = clr_q;
    assign clr_o    = clr_q;
    assign ifm      = ifm_q;
    assign wght     = wght_q;

endmodule

// File: tb/tb_pe_edge_feeder.sv
// Scoreboard bench for pe_edge_feeder: stimulus queues expected PE beats and done events, a monitor compares them.
module tb_pe_edge_feeder;

    localparam int IW = 8;
    localparam int ID = 3;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          busy, done;
    logic          in_valid, in_ready;
    logic [IW-1:0] in_ifm, in_wght;
    logic [ID-1:0] idx;
    logic          mac_done, en_i, en_w, clr_i, clr_w, clr_o, en_o;
    logic [IW-1:0] ifm, wght;

    always #5 clk = ~clk;

    pe_edge_feeder #(.IWIDTH(IW), .IDEPTH(ID), .KWIDTH(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_ifm(in_ifm), .in_wght(in_wght),
        .idx(idx), .mac_done(mac_done), .en_i(en_i), .en_w(en_w),
        .clr_i(clr_i), .clr_w(clr_w), .clr_o(clr_o), .en_o(en_o), .ifm(ifm), .wght(wght)
    );

    typedef struct packed {
        logic [ID-1:0] idx;
        logic          mac_done;
        logic          en_i;
        logic          en_w;
        logic [IW-1:0] ifm;
        logic [IW-1:0] wght;
    } beat_t;

    typedef struct {
        int mac;
        int clr;
    } dexp_t;

    beat_t exp_q[$];
    dexp_t done_q[$];

    int n_chk = 0, n_pass = 0;
    int mac_cnt = 0, clr_cnt = 0, hs_cnt = 0, rdy_cnt = 0;
    int run_len = 0, max_run = 0;
    int exp_mac = 0, exp_clr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        beat_t b;
        dexp_t d;
        bit    prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) hs_cnt++;
            if (in_ready) rdy_cnt++;
            if (mac_done) mac_cnt++;
            if (clr_o) begin
                clr_cnt++;
                chk("clr_pulse", {en_o, en_i, en_w, clr_i, clr_w}, 5'b00011);
            end
            if (en_o) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {idx, ifm, wght}, 0);
                    n_pass--;
                    if ({idx, ifm, wght} == 0) $display("FAIL unexpected_beat: got en_o=1 expected no beat");
                end else begin
                    b = exp_q.pop_front();
                    chk("beat", {idx, mac_done, en_i, en_w, ifm, wght}, b);
                end
            end else begin
                run_len = 0;
                chk("no_strobe_without_en_o", {mac_done, en_i, en_w}, 3'b000);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_mac_count", mac_cnt, d.mac);
                    chk("done_clr_count", clr_cnt, d.clr);
                    chk("busy_at_done", busy, 1'b1);
                end
            end
            if (prev_done) chk("busy_after_done", {busy, done}, 2'b00);
            prev_done = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k);
        start = 1'b1;
        cfg_k = KW'(k);
        exp_clr++;
        step();
        start = 1'b0;
        cfg_k = 8'hA5;
    endtask

    task automatic expect_done(input int k);
        dexp_t d;
        exp_mac += k;
        d.mac = exp_mac;
        d.clr = exp_clr;
        done_q.push_back(d);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b);
        bit    ok;
        beat_t bt;
        in_valid = 1'b1;
        in_ifm   = a;
        in_wght  = b;
        wait_ready(ok);
        if (!ok) begin
            chk("ready_timeout", in_ready, 1'b1);
        end else begin
            step();
            for (int i = 0; i < IW; i++) begin
                bt.idx      = ID'(i);
                bt.mac_done = (i == IW - 1);
                bt.en_i     = (i == 0);
                bt.en_w     = (i == 0);
                bt.ifm      = a;
                bt.wght     = b;
                exp_q.push_back(bt);
            end
        end
        in_valid = 1'b0;
        in_ifm   = 8'h5A;
        in_wght  = 8'hC3;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            step();
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    initial begin : stim
        bit ok;
        int h0, r0;
        rst = 1'b1; start = 1'b0; cfg_k = '0;
        in_valid = 1'b0; in_ifm = '0; in_wght = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset / idle state
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_idle_outputs", {idx, mac_done, en_i, en_w, en_o, clr_i, clr_w, clr_o,
                                       ifm, wght, in_ready, busy, done}, 0);
        end

        // Single MAC with signed operands
        max_run = 0;
        do_start(1);
        expect_done(1);
        send(8'hFD, 8'h05);
        wait_idle();
        chk("k1_slot_len", max_run, IW);

        // Three back-to-back MACs
        max_run = 0;
        h0 = hs_cnt;
        do_start(3);
        expect_done(3);
        send(8'h01, 8'h02);
        send(8'h03, 8'h04);
        send(8'h05, 8'h06);
        wait_idle();
        chk("k3_contiguous_en_o", max_run, 3 * IW);
        chk("k3_handshakes", hs_cnt - h0, 3);

        // Four-cycle stall before the second pair
        do_start(2);
        expect_done(2);
        send(8'h7F, 8'h80);
        wait_ready(ok);
        chk("stall_reach_load", ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_outputs", {en_o, en_i, en_w, mac_done, idx, ifm, wght, in_ready},
                {4'b0000, 3'd0, 8'h7F, 8'h80, 1'b1});
        end
        send(8'h81, 8'h7E);
        wait_idle();

        // Zero-length dot product
        r0 = rdy_cnt;
        do_start(0);
        expect_done(0);
        chk("k0_clear_cycle", {done, busy, clr_o}, 3'b010);
        step();
        chk("k0_done_cycle", {done, busy, clr_o, en_o}, 4'b1110);
        wait_idle();
        chk("k0_never_ready", rdy_cnt - r0, 0);

        // Reset mid-slot aborts without done
        do_start(2);
        send(8'h11, 8'h22);
        for (int i = 0; i < 20; i++) begin
            if (idx == 3'd4) break;
            step();
        end
        chk("abort_reached_idx4", idx, 3'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("abort_outputs_zero", {idx, mac_done, en_i, en_w, en_o, clr_i, clr_w, clr_o,
                                   ifm, wght, in_ready, busy, done}, 0);
        repeat (3) step();
        do_start(1);
        expect_done(1);
        send(8'hF0, 8'h0F);
        wait_idle();

        // start pulse during RUN is ignored
        h0 = hs_cnt;
        do_start(1);
        expect_done(1);
        send(8'h33, 8'hCC);
        step();
        step();
        start = 1'b1;
        cfg_k = 8'd5;
        step();
        start = 1'b0;
        wait_idle();
        chk("run_start_handshakes", hs_cnt - h0, 1);
        repeat (5) step();
        chk("run_start_no_new_txn", {busy, in_ready}, 2'b00);

        repeat (3) step();
        chk("beats_drained", exp_q.size(), 0);
        chk("dones_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
